in_service_ctrl: RTL and testbench

Parametrised in-service register (ISR) controller for the PIC core. Tracks which interrupt requests are being serviced. Sets an ISR bit on the first INTA strobe and clears bits on automatic, non-specific or specific EOI. Adds rotating priority and a set-priority command that the 8-line fixed-priority ISR lacked. Sits between the priority resolver, which supplies the granted index, and the control/command decoder, which supplies EOI and OCW2-style commands.

---
 rtl/pic_pkg.sv | 39 +++
 rtl/rot_prio_encoder.sv | 26 ++
 rtl/in_service_ctrl.sv | 138 +++++++++++++
 tb/tb_in_service_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared PIC definitions: default line count, INTA state encoding and the
// rotated-priority search used by both the resolver and the ISR controller.
package pic_pkg;

    localparam int unsigned N_IRQ_DEFAULT = 8;

    typedef enum logic {
        INTA_IDLE  = 1'b0,
        INTA_ACKED = 1'b1
    } inta_state_e;

    // Index of the first set bit in vec, scanning from lowest+1 upward and wrapping modulo n.
    // Returns 0 when no bit among the low n is set.
    function automatic int unsigned rot_priority_first(
        input logic [31:0] vec,
        input int unsigned lowest,
        input int unsigned n
    );
        int unsigned idx;
        int unsigned res;
        logic        found;
        res   = 0;
        found = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            if (i <= int'(n) && !found) begin
                idx = lowest + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (vec[idx[4:0]]) begin
                    res   = idx;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rot_prio_encoder.sv
// Combinational rotating-priority encoder: picks the highest-priority set bit
// given the current lowest-priority line.
module rot_prio_encoder
    import pic_pkg::*;
#(
    parameter int unsigned N_IRQ = N_IRQ_DEFAULT,
    parameter int unsigned IDX_W = $clog2(N_IRQ)
) (
    input  logic [N_IRQ-1:0] vec_i,
    input  logic [IDX_W-1:0] lowest_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [31:0] vec_ext;
    int unsigned first_idx;

    always_comb begin
        vec_ext              = '0;
        vec_ext[N_IRQ-1:0]   = vec_i;
        first_idx            = rot_priority_first(vec_ext, 32'(lowest_i), N_IRQ);
        idx_o                = IDX_W'(first_idx);
        any_o                = |vec_i;
    end

endmodule

// File: rtl/in_service_ctrl.sv
// In-service register controller: sets ISR bits on INTA, clears them on
// automatic / non-specific / specific EOI, and tracks rotating priority.
module in_service_ctrl
    import pic_pkg::*;
#(
    parameter  int unsigned N_IRQ = N_IRQ_DEFAULT,
    localparam int unsigned IDX_W = $clog2(N_IRQ)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ack1_i,
    input  logic             ack2_i,
    input  logic [IDX_W-1:0] grant_idx_i,
    input  logic             aeoi_en_i,
    input  logic             aeoi_rotate_i,
    input  logic             eoi_vld_i,
    input  logic             eoi_specific_i,
    input  logic             eoi_rotate_i,
    input  logic [IDX_W-1:0] eoi_idx_i,
    input  logic             prio_set_vld_i,
    input  logic [IDX_W-1:0] prio_set_idx_i,
    output logic [N_IRQ-1:0] isr_o,
    output logic [IDX_W-1:0] isr_top_idx_o,
    output logic             isr_any_o,
    output logic [IDX_W-1:0] lowest_prio_o,
    output logic [IDX_W-1:0] last_serviced_o,
    output logic             seq_err_o
);

    inta_state_e      state_q, state_d;
    logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
    logic [N_IRQ-1:0] isr_q, isr_d;
    logic [IDX_W-1:0] lowest_q, lowest_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             seq_err_q, seq_err_d;

    logic [IDX_W-1:0] top_idx;
    logic             isr_any;
    logic             eoi_eff;
    logic [IDX_W-1:0] eoi_clr_idx;
    logic             aeoi_eff;

    rot_prio_encoder #(
        .N_IRQ (N_IRQ),
        .IDX_W (IDX_W)
    ) u_top_enc (
        .vec_i    (isr_q),
        .lowest_i (lowest_q),
        .idx_o    (top_idx),
        .any_o    (isr_any)
    );

    always_comb begin
        state_d     = state_q;
        cur_idx_d   = cur_idx_q;
        isr_d       = isr_q;
        lowest_d    = lowest_q;
        last_d      = last_q;
        seq_err_d   = 1'b0;
        aeoi_eff    = 1'b0;

        // Non-specific EOI with nothing in service is a no-op; out-of-range specific is dropped.
        eoi_clr_idx = eoi_specific_i ? eoi_idx_i : top_idx;
        eoi_eff     = eoi_vld_i &&
                      (eoi_specific_i ? (32'(eoi_idx_i) < N_IRQ) : isr_any);

        unique case (state_q)
            INTA_IDLE: begin
                if (ack2_i) begin
                    seq_err_d = 1'b1;
                end
                if (ack1_i) begin
                    state_d = INTA_ACKED;
                end
            end
            INTA_ACKED: begin
                if (ack1_i) begin
                    seq_err_d = 1'b1;
                end else if (ack2_i) begin
                    state_d  = INTA_IDLE;
                    aeoi_eff = aeoi_en_i;
                end
            end
            default: state_d = INTA_IDLE;
        endcase

        // Clears first, then the set, so an ack1 on a just-cleared bit wins.
        if (aeoi_eff) begin
            isr_d[cur_idx_q] = 1'b0;
            last_d           = cur_idx_q;
            if (aeoi_rotate_i) begin
                lowest_d = cur_idx_q;
            end
        end
        if (eoi_eff) begin
            isr_d[eoi_clr_idx] = 1'b0;
            last_d             = eoi_clr_idx;
            if (eoi_rotate_i) begin
                lowest_d = eoi_clr_idx;
            end
        end
        if (ack1_i) begin
            cur_idx_d = grant_idx_i;
            if (32'(grant_idx_i) < N_IRQ) begin
                isr_d[grant_idx_i] = 1'b1;
            end
        end
        if (prio_set_vld_i && (32'(prio_set_idx_i) < N_IRQ)) begin
            lowest_d = prio_set_idx_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= INTA_IDLE;
            cur_idx_q <= '0;
            isr_q     <= '0;
            lowest_q  <= IDX_W'(N_IRQ - 1);
            last_q    <= '0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_idx_q <= cur_idx_d;
            isr_q     <= isr_d;
            lowest_q  <= lowest_d;
            last_q    <= last_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign isr_o           = isr_q;
    assign isr_top_idx_o   = top_idx;
    assign isr_any_o       = isr_any;
    assign lowest_prio_o   = lowest_q;
    assign last_serviced_o = last_q;
    assign seq_err_o       = seq_err_q;

endmodule

// File: tb/tb_in_service_ctrl.sv
// Directed bench for in_service_ctrl: an 8-line and a 5-line instance share
// stimulus; each section checks hand-computed register values.
module tb_in_service_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       ack1, ack2, aeoi_en, aeoi_rotate;
    logic       eoi_vld, eoi_specific, eoi_rotate, prio_set_vld;
    logic [2:0] grant_idx, eoi_idx, prio_set_idx;

    logic [7:0] isr8;
    logic [2:0] top8, low8, last8;
    logic       any8, serr8;
    logic [4:0] isr5;
    logic [2:0] top5, low5, last5;
    logic       any5, serr5;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    in_service_ctrl #(.N_IRQ(8)) u_dut (
        .clk_i (clk_i), .rst_ni (rst_ni), .ack1_i (ack1), .ack2_i (ack2),
        .grant_idx_i (grant_idx), .aeoi_en_i (aeoi_en), .aeoi_rotate_i (aeoi_rotate),
        .eoi_vld_i (eoi_vld), .eoi_specific_i (eoi_specific), .eoi_rotate_i (eoi_rotate),
        .eoi_idx_i (eoi_idx), .prio_set_vld_i (prio_set_vld), .prio_set_idx_i (prio_set_idx),
        .isr_o (isr8), .isr_top_idx_o (top8), .isr_any_o (any8), .lowest_prio_o (low8),
        .last_serviced_o (last8), .seq_err_o (serr8)
    );

    in_service_ctrl #(.N_IRQ(5)) u_dut5 (
        .clk_i (clk_i), .rst_ni (rst_ni), .ack1_i (ack1), .ack2_i (ack2),
        .grant_idx_i (grant_idx), .aeoi_en_i (aeoi_en), .aeoi_rotate_i (aeoi_rotate),
        .eoi_vld_i (eoi_vld), .eoi_specific_i (eoi_specific), .eoi_rotate_i (eoi_rotate),
        .eoi_idx_i (eoi_idx), .prio_set_vld_i (prio_set_vld), .prio_set_idx_i (prio_set_idx),
        .isr_o (isr5), .isr_top_idx_o (top5), .isr_any_o (any5), .lowest_prio_o (low5),
        .last_serviced_o (last5), .seq_err_o (serr5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic cyc();
        @(negedge clk_i);
        ack1 = 1'b0; ack2 = 1'b0; eoi_vld = 1'b0; prio_set_vld = 1'b0;
    endtask

    task automatic do_ack1(input logic [2:0] g);
        ack1 = 1'b1; grant_idx = g; cyc();
    endtask

    task automatic do_ack2();
        ack2 = 1'b1; cyc();
    endtask

    task automatic do_eoi(input logic spec, input logic rot, input logic [2:0] idx);
        eoi_vld = 1'b1; eoi_specific = spec; eoi_rotate = rot; eoi_idx = idx; cyc();
    endtask

    task automatic do_prio(input logic [2:0] idx);
        prio_set_vld = 1'b1; prio_set_idx = idx; cyc();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; cyc(); rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        ack1 = 0; ack2 = 0; aeoi_en = 0; aeoi_rotate = 0; eoi_vld = 0;
        eoi_specific = 0; eoi_rotate = 0; prio_set_vld = 0;
        grant_idx = 0; eoi_idx = 0; prio_set_idx = 0;
        cyc();
        rst_ni = 1'b1;

        // Reset state
        check("rst_isr", isr8, 8'h00);
        check("rst_lowest", low8, 3'd7);
        check("rst_last", last8, 3'd0);
        check("rst_seq_err", serr8, 1'b0);
        check("rst_any", any8, 1'b0);
        check("rst_top", top8, 3'd0);
        check("rst_lowest5", low5, 3'd4);

        // ack1 grant 3 then ack2 without AEOI
        do_ack1(3);
        check("ack1_isr", isr8, 8'h08);
        do_ack2();
        check("ack2_isr", isr8, 8'h08);
        check("ack2_seq_err", serr8, 1'b0);

        // Non-specific EOI under default and rotated priority
        do_ack1(5); do_ack2();
        check("two_isr", isr8, 8'h28);
        check("two_top", top8, 3'd3);
        do_eoi(0, 0, 0);
        check("nseoi_isr", isr8, 8'h20);
        check("nseoi_last", last8, 3'd3);
        do_ack1(1); do_ack2();
        do_prio(2);
        check("prio_set_lowest", low8, 3'd2);
        check("rot_top", top8, 3'd5);
        do_eoi(0, 0, 0);
        check("rot_nseoi_isr", isr8, 8'h02);
        check("rot_nseoi_last", last8, 3'd5);
        do_eoi(1, 0, 1);
        check("seoi_isr", isr8, 8'h00);
        check("seoi_last", last8, 3'd1);
        do_eoi(0, 1, 0);
        check("empty_nseoi_last", last8, 3'd1);
        check("empty_nseoi_lowest", low8, 3'd2);
        check("empty_any", any8, 1'b0);

        // AEOI with rotation
        aeoi_en = 1; aeoi_rotate = 1;
        do_ack1(4);
        check("aeoi_set_isr", isr8, 8'h10);
        do_ack2();
        check("aeoi_isr", isr8, 8'h00);
        check("aeoi_lowest", low8, 3'd4);
        check("aeoi_last", last8, 3'd4);
        aeoi_en = 0; aeoi_rotate = 0;
        do_ack1(0); do_ack2(); do_ack1(5); do_ack2();
        check("aeoi_rot_isr", isr8, 8'h21);
        check("aeoi_rot_top", top8, 3'd5);
        do_eoi(1, 1, 0);
        check("seoi_rot_isr", isr8, 8'h20);
        check("seoi_rot_lowest", low8, 3'd0);
        do_eoi(0, 0, 0);
        check("seoi_rot_clear", isr8, 8'h00);
        check("seoi_rot_last", last8, 3'd5);

        // Same-cycle: specific EOI and ack1 on the same bit
        do_ack1(2); do_ack2();
        eoi_vld = 1; eoi_specific = 1; eoi_rotate = 0; eoi_idx = 2;
        ack1 = 1; grant_idx = 2;
        cyc();
        check("same_bit_isr", isr8, 8'h04);
        do_ack2();
        check("same_bit_seq", serr8, 1'b0);
        // prio_set beats EOI rotation
        eoi_vld = 1; eoi_specific = 0; eoi_rotate = 1;
        prio_set_vld = 1; prio_set_idx = 6;
        cyc();
        check("prio_win_isr", isr8, 8'h00);
        check("prio_win_lowest", low8, 3'd6);
        // EOI and AEOI in the same cycle
        do_ack1(1); do_ack2(); do_ack1(3);
        aeoi_en = 1; aeoi_rotate = 1;
        ack2 = 1; eoi_vld = 1; eoi_specific = 1; eoi_rotate = 1; eoi_idx = 1;
        cyc();
        check("dual_clr_isr", isr8, 8'h00);
        check("dual_clr_last", last8, 3'd1);
        check("dual_clr_lowest", low8, 3'd1);
        aeoi_en = 0; aeoi_rotate = 0;

        // ack1 while ACKED re-latches
        do_ack1(1); do_ack1(2);
        check("reack_seq", serr8, 1'b1);
        check("reack_isr", isr8, 8'h06);
        aeoi_en = 1;
        do_ack2();
        check("reack_aeoi_isr", isr8, 8'h02);
        check("reack_aeoi_last", last8, 3'd2);
        check("reack_seq_clear", serr8, 1'b0);
        aeoi_en = 0;

        // Sequence errors: ack2 after reset, reset between ack1 and ack2
        do_reset();
        do_ack2();
        check("ack2_idle_seq", serr8, 1'b1);
        check("ack2_idle_isr", isr8, 8'h00);
        cyc();
        check("seq_pulse_end", serr8, 1'b0);
        do_ack1(3);
        check("mid_rst_pre", isr8, 8'h08);
        rst_ni = 1'b0; #2; rst_ni = 1'b1;
        check("mid_rst_isr", isr8, 8'h00);
        do_ack2();
        check("mid_rst_seq", serr8, 1'b1);
        check("mid_rst_isr2", isr8, 8'h00);

        // Five-line instance: wrap and out-of-range handling
        do_reset();
        check("n5_lowest", low5, 3'd4);
        do_ack1(0); do_ack2(); do_ack1(4); do_ack2();
        check("n5_isr", isr5, 5'h11);
        check("n5_top", top5, 3'd0);
        do_eoi(1, 1, 6);
        check("n5_oor_isr", isr5, 5'h11);
        check("n5_oor_lowest", low5, 3'd4);
        check("n5_oor_last", last5, 3'd0);
        do_prio(6);
        check("n5_prio_oor", low5, 3'd4);
        check("n8_prio6", low8, 3'd6);
        do_prio(0);
        check("n5_prio0", low5, 3'd0);
        check("n5_wrap_top", top5, 3'd4);
        check("n5_any", any5, 1'b1);
        check("n5_seq", serr5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
